nibble_serial_add_ctrl: RTL and testbench

- Sequential controller that performs a WIDTH-bit addition by streaming 4-bit slices, LSB first, through the team's existing combinational 4-bit parallel adder, one nibble per clock.
- The adder is instantiated outside this block. This block drives the adder's operand and carry-in inputs and consumes its sum and carry-out, so it is both the adder's upstream feeder and its downstream collector.
- Valid/ready handshakes on both the operand side and the result side.

---
 rtl/nibble_serial_add_ctrl.sv | 151 +++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//
// Performs a WIDTH-bit addition by streaming 4-bit slices, least significant
// nibble first, through an external combinational 4-bit adder. The block
// feeds the adder one nibble per clock and collects each partial sum.
//
// Ports:
//   clk, rst_n               rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready      operand handshake (in_a, in_b, in_cin)
//   add_a, add_b, add_cin    drive the external 4-bit adder (zero outside RUN)
//   add_sum, add_cout        results returned by the external 4-bit adder
//   out_valid / out_ready    result handshake (out_sum, out_cout, out_ovf)
//
// Flow: IDLE accepts operands, RUN performs NIBBLES adder passes, DONE holds
// the result until the consumer takes it. There is no accept-on-consume
// bypass, so accepts are spaced at least NIBBLES+2 cycles apart.

module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  generate
    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : gWidthCheck
      $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  logic [1:0]       stateQ, stateD;
  logic [IdxW-1:0]  idxQ, idxD;
  logic             carryQ, carryD;
  logic [WIDTH-1:0] aQ, aD;
  logic [WIDTH-1:0] bQ, bD;
  logic [WIDTH-1:0] sumQ, sumD;
  logic             coutQ, coutD;

  // Bit offset of the nibble currently being processed (idx * 4).
  logic [IdxW+1:0]  sliceLo;
  logic             isRun;
  logic             isDone;

  assign sliceLo = {idxQ, 2'b00};
  assign isRun   = (stateQ == StRun);
  assign isDone  = (stateQ == StDone);

  always_comb begin
    stateD = stateQ;
    idxD   = idxQ;
    carryD = carryQ;
    aD     = aQ;
    bD     = bQ;
    sumD   = sumQ;
    coutD  = coutQ;

    case (stateQ)
      StIdle: begin
        if (in_valid) begin
          aD     = in_a;
          bD     = in_b;
          carryD = in_cin;
          idxD   = '0;
          stateD = StRun;
        end
      end

      StRun: begin
        sumD[sliceLo +: 4] = add_sum;
        carryD             = add_cout;
        if (idxQ == LastIdx) begin
          coutD  = add_cout;
          idxD   = '0;
          stateD = StDone;
        end else begin
          idxD = idxQ + IdxW'(1);
        end
      end

      StDone: begin
        if (out_ready) begin
          stateD = StIdle;
        end
      end

      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StIdle;
      idxQ   <= '0;
      carryQ <= 1'b0;
      aQ     <= '0;
      bQ     <= '0;
      sumQ   <= '0;
      coutQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      idxQ   <= idxD;
      carryQ <= carryD;
      aQ     <= aD;
      bQ     <= bD;
      sumQ   <= sumD;
      coutQ  <= coutD;
    end
  end

  // Adder inputs come only from registers, so there is no combinational path
  // from the operand port through the external adder back into this block.
  assign add_a   = isRun ? aQ[sliceLo +: 4] : 4'h0;
  assign add_b   = isRun ? bQ[sliceLo +: 4] : 4'h0;
  assign add_cin = isRun & carryQ;

  assign in_ready  = (stateQ == StIdle);
  assign out_valid = isDone;

  // Result outputs are forced to zero outside DONE so that nothing partial
  // is ever visible to the consumer.
  assign out_sum  = isDone ? sumQ : '0;
  assign out_cout = isDone & coutQ;
  assign out_ovf  = isDone & (aQ[WIDTH-1] == bQ[WIDTH-1]) & (sumQ[WIDTH-1] != aQ[WIDTH-1]);

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;

  localparam int Nib = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  int nCmp = 0;
  int nBad = 0;
  int cyc  = 0;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  // The external 4-bit parallel adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted request yields a+b+cin after Nib
  // cycles; the result is held until taken, and a new request is accepted
  // only once the previous result has been taken.
  logic [17:0] expQ[$];   // {ovf, cout, sum}
  logic        mBusy;
  logic        mValid;
  int          mCnt;

  initial begin
    mBusy  = 1'b0;
    mValid = 1'b0;
    mCnt   = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mBusy  = 1'b0;
        mValid = 1'b0;
        mCnt   = 0;
        expQ.delete();
      end else if (!mBusy) begin
        if (in_valid) begin
          logic [16:0] full;
          int          s;
          full = {1'b0, in_a} + {1'b0, in_b} + {16'h0000, in_cin};
          s    = int'($signed(in_a)) + int'($signed(in_b)) + int'(in_cin);
          expQ.push_back({((s > 32767) || (s < -32768)), full});
          mBusy = 1'b1;
          mCnt  = Nib;
        end
      end else if (!mValid) begin
        mCnt--;
        if (mCnt == 0) mValid = 1'b1;
      end else if (out_ready) begin
        mValid = 1'b0;
        mBusy  = 1'b0;
        void'(expQ.pop_front());
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(!mBusy));
      chk("out_valid", 32'(out_valid), 32'(mValid));
      if (mValid && (expQ.size() > 0)) begin
        chk("out_sum", 32'(out_sum), 32'(expQ[0][15:0]));
        chk("out_cout", 32'(out_cout), 32'(expQ[0][16]));
        chk("out_ovf", 32'(out_ovf), 32'(expQ[0][17]));
      end
      if (!mBusy || mValid) begin
        chk("adder_idle", 32'({add_a, add_b, add_cin}), 32'd0);
      end
    end
  end

  // Record each result as it first appears.
  logic [15:0] gotQ[$];
  logic        prevValid = 1'b0;
  always @(negedge clk) begin
    if (out_valid && !prevValid) gotQ.push_back(out_sum);
    prevValid <= out_valid;
  end

  task automatic chkResetOutputs(input string nm);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({nm, "_outs"}, 32'({out_valid, out_cout, out_ovf, out_sum}), 32'd0);
    chk({nm, "_adder"}, 32'({add_a, add_b, add_cin}), 32'd0);
  endtask

  // Called at a negedge. Submits one request, checks latency and the
  // hand-computed result, holds off the consumer for 'hold' cycles, then
  // takes the result.
  task automatic doOp(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [15:0] es, input logic ec, input logic eo,
                      input int hold, input string nm, output logic [3:0] cins);
    int n;
    cins      = 4'h0;
    in_a      = a;
    in_b      = b;
    in_cin    = c;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_accept_timeout"}, 32'(n >= 50), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      if (n < 4) cins[n] = add_cin;
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(Nib));
    chk({nm, "_sum"}, 32'(out_sum), 32'(es));
    chk({nm, "_cout"}, 32'(out_cout), 32'(ec));
    chk({nm, "_ovf"}, 32'(out_ovf), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({nm, "_hold_sum"}, 32'(out_sum), 32'(es));
      chk({nm, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [3:0]  cins;
    logic [15:0] pa[3];
    logic [15:0] pb[3];
    logic [15:0] pe[3];
    int          acc[3];
    int          n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 16'h0000;
    in_b      = 16'h0000;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    #3;
    chkResetOutputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    doOp(16'h1234, 16'h0FCC, 1'b0, 16'h2200, 1'b0, 1'b0, 0, "basic", cins);

    doOp(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, "ripple", cins);
    chk("ripple_cin_seq", 32'(cins), 32'(4'b1110));

    doOp(16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 0, "posovf", cins);
    doOp(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0, "negovf", cins);

    doOp(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 5, "bp", cins);

    // Reset in the middle of RUN.
    in_a     = 16'hAAAA;
    in_b     = 16'h5555;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chkResetOutputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    doOp(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 0, "post_reset", cins);

    // Back-to-back requests with the consumer always ready.
    pa = '{16'h0001, 16'h1000, 16'hFFFE};
    pb = '{16'h0001, 16'h1000, 16'h0001};
    pe = '{16'h0002, 16'h2000, 16'hFFFF};
    gotQ.delete();
    out_ready = 1'b1;
    in_cin    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_a     = pa[i];
      in_b     = pb[i];
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_accept_timeout", 32'(n >= 50), 32'd0);
      @(negedge clk);
      acc[i] = cyc;
    end
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_spacing_01", 32'(acc[1] - acc[0]), 32'd6);
    chk("b2b_spacing_12", 32'(acc[2] - acc[1]), 32'd6);
    chk("b2b_count", 32'(gotQ.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < gotQ.size()) chk("b2b_result", 32'(gotQ[i]), 32'(pe[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
